// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction-fetch slice.
//   FETCH_PKT_W         : width of the fetch packet driven to pre-decode
//   TAG_BIT/INSTR/PC    : field positions inside the fetch packet
//   fetch_state_t       : fetch FSM states
//   queue_entry_t       : one prefetch-queue entry {instruction, PC}
//   make_packet()       : builds a fetch packet from a tag and a queue entry
package CPU_Types;

  localparam int unsigned FETCH_PKT_W = 121;
  localparam int unsigned TAG_BIT     = 120;
  localparam int unsigned INSTR_MSB   = 119;
  localparam int unsigned INSTR_LSB   = 88;
  localparam int unsigned PC_MSB      = 87;
  localparam int unsigned PC_LSB      = 56;
  localparam int unsigned PAD_W       = 56;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } queue_entry_t;

  function automatic logic [FETCH_PKT_W-1:0] make_packet(input logic tag,
                                                         input queue_entry_t e);
    return {tag, e.instr, e.pc, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// Prefetch FIFO of {instruction, PC} pairs.
//   i_clock / i_reset : clock, asynchronous active-low reset
//   push / push_entry : write an entry (accepted when not full, or when a pop
//                       happens in the same cycle)
//   pop               : drop the head entry (ignored when empty)
//   flush             : empty the queue; wins over push and pop
//   head              : current head entry (valid when !empty)
//   full / empty      : occupancy flags
//   count             : current number of entries
module cpu_fetch_queue
  import CPU_Types::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           push,
  input  queue_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output queue_entry_t                   head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(QUEUE_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  queue_entry_t   mem [QUEUE_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(QUEUE_DEPTH));
    do_pop  = pop && !empty;
    // A pop frees the slot before the push lands, so a full queue can take both.
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
    count   = count_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge i_clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: issues single outstanding word reads on the
// instruction bus, buffers returned words in a prefetch queue and hands them
// to pre-decode as a tagged fetch packet.
//   RESET_VECTOR  : PC of the first fetch after reset
//   QUEUE_DEPTH   : prefetch queue entries (2 or 4)
//   i_clock       : clock, rising edge
//   i_reset       : asynchronous active-low reset
//   o_bus_request : instruction-bus read request
//   o_bus_address : word-aligned read address
//   i_bus_ready   : read completes this cycle, i_bus_rdata valid
//   i_bus_rdata   : instruction word
//   i_stall       : pre-decode cannot take a new instruction this cycle
//   i_jump        : redirect strobe from execute
//   i_jump_pc     : redirect target
//   o_data        : {tag, instruction, PC, 56'b0}; tag flips on every new packet
module cpu_fetch
  import CPU_Types::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH  = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  output logic                   o_bus_request,
  output logic [31:0]            o_bus_address,
  input  logic                   i_bus_ready,
  input  logic [31:0]            i_bus_rdata,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [31:0]            i_jump_pc,
  output logic [FETCH_PKT_W-1:0] o_data
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(QUEUE_DEPTH - 1);

  fetch_state_t             state_q;
  logic [31:0]              fetch_pc_q;
  logic [31:0]              pend_pc_q;
  logic                     req_q;
  logic [31:0]              addr_q;
  logic [FETCH_PKT_W-1:0]   data_q;

  logic                     accept;
  logic                     q_push;
  logic                     q_pop;
  logic                     q_flush;
  logic                     q_full;
  logic                     q_empty;
  logic [CW-1:0]            q_count;
  queue_entry_t             q_head;
  queue_entry_t             q_in;
  logic                     goes_full;
  logic [31:0]              pc_plus4;
  logic [31:0]              drain_target;

  cpu_fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .push       (q_push),
    .push_entry (q_in),
    .pop        (q_pop),
    .flush      (q_flush),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  always_comb begin
    accept       = req_q && i_bus_ready;
    q_flush      = i_jump;
    q_pop        = !i_jump && !i_stall && !q_empty;
    q_push       = (state_q == FETCH) && accept && !i_jump && (!q_full || q_pop);
    q_in.instr   = i_bus_rdata;
    q_in.pc      = fetch_pc_q;
    // Queue is full after this edge: stop requesting so no read is left dangling.
    goes_full    = q_push && !q_pop && (q_count == LAST_SLOT);
    pc_plus4     = fetch_pc_q + 32'd4;
    // A jump arriving on the same edge the drained read completes still wins.
    drain_target = i_jump ? i_jump_pc : pend_pc_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_VECTOR;
      pend_pc_q  <= RESET_VECTOR;
      req_q      <= 1'b0;
      addr_q     <= RESET_VECTOR;
      data_q     <= '0;
    end else begin
      if (q_pop) data_q <= make_packet(~data_q[TAG_BIT], q_head);

      case (state_q)
        FETCH: begin
          if (i_jump) begin
            if (req_q && !i_bus_ready) begin
              // Read in flight: keep the bus request stable and drop its data later.
              state_q   <= DRAIN;
              pend_pc_q <= i_jump_pc;
            end else begin
              fetch_pc_q <= i_jump_pc;
              addr_q     <= i_jump_pc;
              req_q      <= 1'b1;
            end
          end else if (q_push) begin
            fetch_pc_q <= pc_plus4;
            addr_q     <= pc_plus4;
            if (goes_full) begin
              state_q <= FULL;
              req_q   <= 1'b0;
            end else begin
              req_q   <= 1'b1;
            end
          end else begin
            req_q <= 1'b1;
          end
        end

        FULL: begin
          if (i_jump) begin
            state_q    <= FETCH;
            fetch_pc_q <= i_jump_pc;
            addr_q     <= i_jump_pc;
            req_q      <= 1'b1;
          end else if (q_pop) begin
            state_q <= FETCH;
            addr_q  <= fetch_pc_q;
            req_q   <= 1'b1;
          end
        end

        DRAIN: begin
          if (accept) begin
            state_q    <= FETCH;
            fetch_pc_q <= drain_target;
            addr_q     <= drain_target;
            req_q      <= 1'b1;
          end else if (i_jump) begin
            pend_pc_q <= i_jump_pc;
          end
        end

        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_bus_request = req_q;
  assign o_bus_address = addr_q;
  assign o_data        = data_q;

endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic         i_clock;
  logic         i_reset;
  logic         o_bus_request;
  logic [31:0]  o_bus_address;
  logic         i_bus_ready;
  logic [31:0]  i_bus_rdata;
  logic         i_stall;
  logic         i_jump;
  logic [31:0]  i_jump_pc;
  logic [120:0] o_data;

  int unsigned total;
  int unsigned passed;

  cpu_fetch #(
    .RESET_VECTOR (32'h0000_0100),
    .QUEUE_DEPTH  (2)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_bus_request (o_bus_request),
    .o_bus_address (o_bus_address),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .i_stall       (i_stall),
    .i_jump        (i_jump),
    .i_jump_pc     (i_jump_pc),
    .o_data        (o_data)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [120:0] pkt(input logic tag, input logic [31:0] pc);
    logic [31:0] instr;
    instr = pc ^ K;
    return {tag, instr, pc, 56'h0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; the memory model returns addr^K for the current address.
  task automatic tick();
    @(posedge i_clock);
    #1;
    i_bus_rdata = o_bus_address ^ K;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    i_reset     = 1'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    i_stall     = 1'b0;
    i_jump      = 1'b0;
    i_jump_pc   = '0;

    tick(); tick();
    check("rst_req",  128'(o_bus_request), 128'(1'b0));
    check("rst_data", 128'(o_data),        128'(121'h0));
    i_reset     = 1'b1;
    i_bus_ready = 1'b1;

    tick(); // E1
    check("first_req",  128'(o_bus_request), 128'(1'b1));
    check("first_addr", 128'(o_bus_address), 128'(32'h100));
    tick(); // E2
    check("e2_addr", 128'(o_bus_address), 128'(32'h104));
    check("e2_data", 128'(o_data),        128'(121'h0));
    tick(); // E3
    check("e3_data", 128'(o_data),        128'(pkt(1'b1, 32'h100)));
    check("e3_addr", 128'(o_bus_address), 128'(32'h108));
    tick(); // E4
    check("e4_data", 128'(o_data), 128'(pkt(1'b0, 32'h104)));
    tick(); // E5
    check("e5_data", 128'(o_data), 128'(pkt(1'b1, 32'h108)));
    i_stall = 1'b1;

    tick(); // E6
    check("stall_full_req", 128'(o_bus_request), 128'(1'b0));
    check("stall_data6",    128'(o_data),        128'(pkt(1'b1, 32'h108)));
    tick(); tick(); // E8
    check("stall_req8",  128'(o_bus_request), 128'(1'b0));
    check("stall_data8", 128'(o_data),        128'(pkt(1'b1, 32'h108)));
    tick(); tick(); // E10
    check("stall_data10", 128'(o_data), 128'(pkt(1'b1, 32'h108)));
    i_stall = 1'b0;

    tick(); // E11
    check("rel_data11", 128'(o_data),        128'(pkt(1'b0, 32'h10C)));
    check("rel_req11",  128'(o_bus_request), 128'(1'b1));
    check("rel_addr11", 128'(o_bus_address), 128'(32'h114));
    tick(); // E12
    check("rel_data12", 128'(o_data),        128'(pkt(1'b1, 32'h110)));
    check("rel_addr12", 128'(o_bus_address), 128'(32'h118));
    tick(); // E13
    check("rel_data13", 128'(o_data), 128'(pkt(1'b0, 32'h114)));
    i_bus_ready = 1'b0;

    tick(); // E14
    check("wait_data14", 128'(o_data),        128'(pkt(1'b1, 32'h118)));
    check("wait_addr14", 128'(o_bus_address), 128'(32'h11C));
    i_jump    = 1'b1;
    i_jump_pc = 32'h2000;

    tick(); // E15
    check("drain_addr15", 128'(o_bus_address), 128'(32'h11C));
    check("drain_req15",  128'(o_bus_request), 128'(1'b1));
    check("drain_data15", 128'(o_data),        128'(pkt(1'b1, 32'h118)));
    i_jump = 1'b0;
    tick(); tick(); // E17
    check("drain_addr17", 128'(o_bus_address), 128'(32'h11C));
    check("drain_req17",  128'(o_bus_request), 128'(1'b1));
    i_bus_ready = 1'b1;

    tick(); // E18
    check("drain_target", 128'(o_bus_address), 128'(32'h2000));
    check("drain_data18", 128'(o_data),        128'(pkt(1'b1, 32'h118)));
    tick(); // E19
    check("jmp_addr19", 128'(o_bus_address), 128'(32'h2004));
    check("jmp_data19", 128'(o_data),        128'(pkt(1'b1, 32'h118)));
    tick(); // E20
    check("jmp_data20", 128'(o_data),        128'(pkt(1'b0, 32'h2000)));
    check("jmp_addr20", 128'(o_bus_address), 128'(32'h2008));
    i_jump    = 1'b1;
    i_jump_pc = 32'h40;

    tick(); // E21
    check("jr_addr21", 128'(o_bus_address), 128'(32'h40));
    check("jr_data21", 128'(o_data),        128'(pkt(1'b0, 32'h2000)));
    i_jump = 1'b0;
    tick(); // E22
    check("jr_flushed", 128'(o_data),        128'(pkt(1'b0, 32'h2000)));
    check("jr_addr22",  128'(o_bus_address), 128'(32'h44));
    tick(); // E23
    check("jr_data23", 128'(o_data), 128'(pkt(1'b1, 32'h40)));
    i_jump    = 1'b1;
    i_jump_pc = 32'hFFFF_FFFC;

    tick(); // E24
    check("wrap_addr24", 128'(o_bus_address), 128'(32'hFFFF_FFFC));
    i_jump = 1'b0;
    tick(); // E25
    check("wrap_addr25", 128'(o_bus_address), 128'(32'h0));
    tick(); // E26
    check("wrap_data26", 128'(o_data),        128'(pkt(1'b0, 32'hFFFF_FFFC)));
    check("wrap_addr26", 128'(o_bus_address), 128'(32'h4));
    i_bus_ready = 1'b0;
    i_jump      = 1'b1;
    i_jump_pc   = 32'h500;

    tick(); // E27
    check("dj_addr27", 128'(o_bus_address), 128'(32'h4));
    check("dj_data27", 128'(o_data),        128'(pkt(1'b0, 32'hFFFF_FFFC)));
    i_jump_pc = 32'h600;
    tick(); // E28
    check("dj_addr28", 128'(o_bus_address), 128'(32'h4));
    i_jump      = 1'b0;
    i_bus_ready = 1'b1;
    tick(); // E29
    check("dj_last_wins", 128'(o_bus_address), 128'(32'h600));
    i_bus_ready = 1'b0;

    tick(); // E30
    check("mid_req30", 128'(o_bus_request), 128'(1'b1));
    #3;
    i_reset = 1'b0;
    #1;
    check("async_req",  128'(o_bus_request), 128'(1'b0));
    check("async_data", 128'(o_data),        128'(121'h0));
    i_bus_ready = 1'b1;
    tick(); // E31, still in reset
    check("rst_hold_req", 128'(o_bus_request), 128'(1'b0));
    i_reset = 1'b1;
    tick(); // E32: late ready ignored while request is low
    check("rr_req",  128'(o_bus_request), 128'(1'b1));
    check("rr_addr", 128'(o_bus_address), 128'(32'h100));
    check("rr_data", 128'(o_data),        128'(121'h0));
    tick(); // E33
    check("rr_data33", 128'(o_data),        128'(121'h0));
    check("rr_addr33", 128'(o_bus_address), 128'(32'h104));
    tick(); // E34
    check("rr_data34", 128'(o_data), 128'(pkt(1'b1, 32'h100)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, is the PC of the first fetch after reset.
REQ-002 Parameter QUEUE_DEPTH, default 2, is the number of prefetch queue entries; legal values are 2 and 4.
REQ-003 i_clock  in  1  is the single clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  is the asynchronous, active-low reset.
REQ-005 o_bus_request  out  1  requests an instruction-bus read.
REQ-006 o_bus_address  out  32  is the read address, word-aligned.
REQ-007 i_bus_ready  in  1  completes the current read; i_bus_rdata is valid in the same cycle.
REQ-008 i_bus_rdata  in  32  is the instruction word.
REQ-009 i_stall  in  1  means the downstream pre-decode stage must not receive a new instruction this cycle.
REQ-010 i_jump  in  1  is a single-cycle redirect strobe from execute.
REQ-011 i_jump_pc  in  32  is the redirect target, sampled when i_jump=1.
REQ-012 o_data  out  121  is the fetch packet: [120] tag, [119:88] instruction, [87:56] PC, [55:0] zero.

Function
REQ-013 The block SHALL keep a fetch PC, a QUEUE_DEPTH-entry FIFO of {instruction, PC} pairs, and a registered o_data.
REQ-014 The FSM SHALL have three states: FETCH, FULL and DRAIN.
  - FETCH: o_bus_request=1 and o_bus_address=fetch PC.
  - FULL: entered when the queue has no free slot; o_bus_request=0.
  - DRAIN: entered on i_jump while a read is outstanding.
REQ-015 While o_bus_request=1 and i_bus_ready=0, the block SHALL hold o_bus_address and o_bus_request stable.
REQ-016 On i_bus_ready=1 in FETCH, the block SHALL push {i_bus_rdata, fetch PC} and set fetch PC to fetch PC+4, with 32-bit wrap-around (FFFF_FFFC+4 -> 0).
REQ-017 The block SHALL have at most one bus read outstanding.
REQ-018 FULL SHALL return to FETCH in the cycle after a pop frees a slot.
REQ-019 A pop and a push in the same cycle SHALL be legal when the queue is full; the pop is taken first and the FSM stays in FETCH.
REQ-020 When i_stall=0 and the queue is not empty, the block SHALL pop the head into o_data[119:56] and invert o_data[120] (tag).
REQ-021 When i_stall=1 or the queue is empty, o_data SHALL hold its value, so the tag does not toggle.
REQ-022 Latency: a word accepted at edge N SHALL appear on o_data no earlier than edge N+1, and exactly at N+1 when the queue was empty and i_stall=0.
REQ-023 i_jump=1 SHALL take priority over push and pop in the same cycle:
  - flush the queue;
  - load fetch PC with i_jump_pc;
  - leave o_data unchanged.
REQ-024 i_jump during an outstanding read (request=1, ready=0) SHALL go to DRAIN.
  - DRAIN keeps o_bus_request and o_bus_address at their pre-jump values until i_bus_ready.
  - The returned word SHALL be discarded.
  - The FSM then enters FETCH at i_jump_pc.
REQ-025 i_jump in the same cycle as i_bus_ready SHALL discard that word and go directly to FETCH at i_jump_pc.
REQ-026 A second i_jump while in DRAIN SHALL overwrite the pending target; the last target wins.
REQ-027 o_data[55:0] SHALL always be zero.

Reset
REQ-028 While i_reset=0, the block SHALL immediately set:
  - o_bus_request=0;
  - o_data=0 (including tag);
  - queue empty;
  - FSM in FETCH;
  - fetch PC=RESET_VECTOR.
REQ-029 The first bus request SHALL assert in the first cycle after i_reset rises, with o_bus_address=RESET_VECTOR.
REQ-030 Reset asserted mid-read SHALL abandon the read; a late i_bus_ready after reset release SHALL be ignored only if o_bus_request=0 in that cycle.

Structure
REQ-031 The shared package CPU_Types SHALL define:
  - the 121-bit fetch-packet width;
  - field offsets (TAG 120, INSTR 119:88, PC 87:56);
  - the FSM state enum.
REQ-032 The FIFO SHALL be the sub-module cpu_fetch_queue, with push, pop, flush, full and empty ports, parameterised by QUEUE_DEPTH.

Verification
REQ-033 Reset release with RESET_VECTOR=0x100 and i_bus_ready tied to 1 -> addresses 0x100, 0x104, 0x108.
  - o_data[87:56] is 0x100 one cycle after the first ready.
  - The tag toggles every cycle.
REQ-034 i_stall=1 for 5 cycles with ready=1 -> two words queued, then o_bus_request=0 (FULL) and o_data stable.
  - On release, the PCs continue in order with none lost or duplicated.
REQ-035 Read outstanding with ready delayed 3 cycles, i_jump=1 to 0x2000 -> the old address is held until ready.
  - The returned word is not seen on o_data.
  - The next address is 0x2000.
REQ-036 i_jump and i_bus_ready in the same cycle, target 0x40 -> the word is dropped, the next address is 0x40, and the queue is empty.
REQ-037 PC 0xFFFFFFFC fetched -> the next address is 0x00000000.
REQ-038 i_reset low mid-read -> o_bus_request=0 and o_data=0 asynchronously, before the next clock edge.
